vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 113 +++++++++++
 tb/tb_vga_timing_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: clock-enable divider, h/v counters, registered sync/blank/strobes.
// Optional colour-bar test pattern on rgb when VGA_TIMING_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             hSync,
  output logic             vSync,
  output logic             bright,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             pix_tick,
  output logic             line_start,
  output logic             frame_start,
  output logic [11:0]      rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             hs_next;
  logic             vs_next;
  logic             br_next;
  logic [11:0]      rgb_next;

  // Outputs are decoded from the next counter values so they land on the same edge as the counters.
  always_comb begin
    tick   = (div_cnt == DIV_LAST);
    h_next = hCount;
    v_next = vCount;
    if (tick) begin
      if (hCount >= H_LAST) begin
        h_next = '0;
        v_next = (vCount >= V_LAST) ? '0 : vCount + CNT_W'(1);
      end else begin
        h_next = hCount + CNT_W'(1);
      end
    end
    hs_next = (h_next >= H_SYNC_LO && h_next <= H_SYNC_HI) ? HS_POL : ~HS_POL;
    vs_next = (v_next >= V_SYNC_LO && v_next <= V_SYNC_HI) ? VS_POL : ~VS_POL;
    br_next = (h_next < H_ACT) && (v_next < V_ACT);
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                       12'hF0F, 12'hF00, 12'h00F, 12'h000};
  logic [CNT_W-1:0] bar_idx;
  logic [2:0]       bar_sel;

  always_comb begin
    bar_idx  = h_next / CNT_W'(BAR_W);
    bar_sel  = (bar_idx > CNT_W'(7)) ? 3'd7 : bar_idx[2:0];
    rgb_next = br_next ? BARS[bar_sel] : 12'h000;
  end
`else
  assign rgb_next = 12'h000;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      hCount      <= H_LAST;
      vCount      <= V_LAST;
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hSync       <= ~HS_POL;
      vSync       <= ~VS_POL;
      bright      <= 1'b0;
      rgb         <= 12'h000;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + DIV_W'(1);
      hCount      <= h_next;
      vCount      <= v_next;
      pix_tick    <= tick;
      line_start  <= tick && (h_next == '0);
      frame_start <= tick && (h_next == '0) && (v_next == '0);
      hSync       <= hs_next;
      vSync       <= vs_next;
      bright      <= br_next;
      rgb         <= rgb_next;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny-geometry instance (CLK_DIV=1, HS_POL=1).
// rgb expectations follow VGA_TIMING_TEST_PATTERN_EN when that macro is defined.
module tb_vga_timing_gen;

  typedef struct {
    int          adv;
    int          h;
    int          v;
    bit          hs;
    bit          vs;
    bit          br;
    bit          ls;
    bit          fs;
    bit          pt;
    bit          crgb;
    logic [11:0] rgb;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst_s_n;
  logic       hs, vs, br, pt, ls, fs;
  logic [9:0] hc, vc;
  logic [11:0] rgb;
  logic       hs_s, vs_s, br_s, pt_s, ls_s, fs_s;
  logic [9:0] hc_s, vc_s;
  logic [11:0] rgb_s;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  vga_timing_gen dut (
    .clk(clk), .reset_n(rst_n), .hSync(hs), .vSync(vs), .bright(br),
    .hCount(hc), .vCount(vc), .pix_tick(pt), .line_start(ls),
    .frame_start(fs), .rgb(rgb)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(10)
  ) dut_s (
    .clk(clk), .reset_n(rst_s_n), .hSync(hs_s), .vSync(vs_s), .bright(br_s),
    .hCount(hc_s), .vCount(vc_s), .pix_tick(pt_s), .line_start(ls_s),
    .frame_start(fs_s), .rgb(rgb_s)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input logic [11:0] pat);
`ifdef VGA_TIMING_TEST_PATTERN_EN
    return pat;
`else
    return 12'h000;
`endif
  endfunction

  function automatic vec_t mk(input int adv, input int h, input int v, input bit hs_e,
                              input bit vs_e, input bit br_e, input bit ls_e, input bit fs_e,
                              input bit pt_e, input bit crgb, input logic [11:0] rgb_e);
    vec_t e;
    e.adv = adv; e.h = h; e.v = v; e.hs = hs_e; e.vs = vs_e; e.br = br_e;
    e.ls = ls_e; e.fs = fs_e; e.pt = pt_e; e.crgb = crgb; e.rgb = rgb_e;
    return e;
  endfunction

  function automatic vec_t snap_b();
    return mk(0, int'(hc), int'(vc), hs, vs, br, ls, fs, pt, 1'b1, rgb);
  endfunction

  function automatic vec_t snap_s();
    return mk(0, int'(hc_s), int'(vc_s), hs_s, vs_s, br_s, ls_s, fs_s, pt_s, 1'b1, rgb_s);
  endfunction

  task automatic cmp_vec(input string tag, input int i, input vec_t e, input vec_t a);
    chk($sformatf("%s[%0d].hCount", tag, i), a.h, e.h);
    chk($sformatf("%s[%0d].vCount", tag, i), a.v, e.v);
    chk($sformatf("%s[%0d].hSync", tag, i), int'(a.hs), int'(e.hs));
    chk($sformatf("%s[%0d].vSync", tag, i), int'(a.vs), int'(e.vs));
    chk($sformatf("%s[%0d].bright", tag, i), int'(a.br), int'(e.br));
    chk($sformatf("%s[%0d].line_start", tag, i), int'(a.ls), int'(e.ls));
    chk($sformatf("%s[%0d].frame_start", tag, i), int'(a.fs), int'(e.fs));
    chk($sformatf("%s[%0d].pix_tick", tag, i), int'(a.pt), int'(e.pt));
    if (e.crgb) chk($sformatf("%s[%0d].rgb", tag, i), int'(a.rgb), int'(exp_rgb(e.rgb)));
  endtask

  initial begin
    vec_t big_tab[$];
    vec_t small_tab[$];
    int cyc, n_hs, n_vs, n_br, n_pt, n_ls, n_fs, n_rgb, max_h, max_v, last_fs;

    // Cumulative clocks after release in the right-hand comment; pixel h sits at clk 4+4*h on line 0.
    big_tab.push_back(mk(3,    799, 524, 1, 1, 0, 0, 0, 0, 1, 12'h000)); // clk 3
    big_tab.push_back(mk(1,    0,   0,   1, 1, 1, 1, 1, 1, 1, 12'hFFF)); // clk 4
    big_tab.push_back(mk(1,    0,   0,   1, 1, 1, 0, 0, 0, 1, 12'hFFF)); // clk 5
    big_tab.push_back(mk(3,    1,   0,   1, 1, 1, 0, 0, 1, 1, 12'hFFF)); // clk 8
    big_tab.push_back(mk(312,  79,  0,   1, 1, 1, 0, 0, 1, 1, 12'hFFF));
    big_tab.push_back(mk(4,    80,  0,   1, 1, 1, 0, 0, 1, 1, 12'hFF0));
    big_tab.push_back(mk(316,  159, 0,   1, 1, 1, 0, 0, 1, 1, 12'hFF0));
    big_tab.push_back(mk(4,    160, 0,   1, 1, 1, 0, 0, 1, 1, 12'h0FF));
    big_tab.push_back(mk(1600, 560, 0,   1, 1, 1, 0, 0, 1, 1, 12'h000));
    big_tab.push_back(mk(316,  639, 0,   1, 1, 1, 0, 0, 1, 1, 12'h000));
    big_tab.push_back(mk(4,    640, 0,   1, 1, 0, 0, 0, 1, 1, 12'h000));
    big_tab.push_back(mk(60,   655, 0,   1, 1, 0, 0, 0, 1, 1, 12'h000));
    big_tab.push_back(mk(4,    656, 0,   0, 1, 0, 0, 0, 1, 1, 12'h000));
    big_tab.push_back(mk(380,  751, 0,   0, 1, 0, 0, 0, 1, 1, 12'h000));
    big_tab.push_back(mk(4,    752, 0,   1, 1, 0, 0, 0, 1, 1, 12'h000));
    big_tab.push_back(mk(188,  799, 0,   1, 1, 0, 0, 0, 1, 1, 12'h000)); // clk 3200
    big_tab.push_back(mk(4,    0,   1,   1, 1, 1, 1, 0, 1, 1, 12'hFFF)); // clk 3204

    // Tiny geometry: 8x6 totals, one pixel per clk, hSync high at h 5..6, vSync low on line 4.
    small_tab.push_back(mk(1,  0, 0, 0, 1, 1, 1, 1, 1, 0, 12'h000));
    small_tab.push_back(mk(1,  1, 0, 0, 1, 1, 0, 0, 1, 0, 12'h000));
    small_tab.push_back(mk(4,  5, 0, 1, 1, 0, 0, 0, 1, 1, 12'h000));
    small_tab.push_back(mk(1,  6, 0, 1, 1, 0, 0, 0, 1, 1, 12'h000));
    small_tab.push_back(mk(1,  7, 0, 0, 1, 0, 0, 0, 1, 1, 12'h000));
    small_tab.push_back(mk(1,  0, 1, 0, 1, 1, 1, 0, 1, 0, 12'h000));
    small_tab.push_back(mk(16, 0, 3, 0, 1, 0, 1, 0, 1, 1, 12'h000));
    small_tab.push_back(mk(8,  0, 4, 0, 0, 0, 1, 0, 1, 1, 12'h000));
    small_tab.push_back(mk(7,  7, 4, 0, 0, 0, 0, 0, 1, 1, 12'h000));
    small_tab.push_back(mk(1,  0, 5, 0, 1, 0, 1, 0, 1, 1, 12'h000));
    small_tab.push_back(mk(7,  7, 5, 0, 1, 0, 0, 0, 1, 1, 12'h000));
    small_tab.push_back(mk(1,  0, 0, 0, 1, 1, 1, 1, 1, 0, 12'h000));

    rst_n   = 1'b0;
    rst_s_n = 1'b0;
    repeat (3) @(negedge clk);
    cmp_vec("rst_big", 0, mk(0, 799, 524, 1, 1, 0, 0, 0, 0, 1, 12'h000), snap_b());
    cmp_vec("rst_small", 0, mk(0, 7, 5, 0, 1, 0, 0, 0, 0, 1, 12'h000), snap_s());

    // Small instance: table, then two-frame scan, then mid-frame reset.
    rst_s_n = 1'b1;
    for (int i = 0; i < small_tab.size(); i++) begin
      repeat (small_tab[i].adv) @(negedge clk);
      cmp_vec("small", i, small_tab[i], snap_s());
    end

    exp_q.push_back(16'd48);
    exp_q.push_back(16'd48);
    n_hs = 0; n_vs = 0; n_br = 0; n_pt = 0; n_ls = 0; n_fs = 0; n_rgb = 0;
    max_h = 0; max_v = 0; last_fs = 0;
    for (int c = 1; c <= 96; c++) begin
      @(negedge clk);
      if (hs_s) n_hs++;
      if (!vs_s) n_vs++;
      if (br_s) n_br++;
      if (pt_s) n_pt++;
      if (ls_s) n_ls++;
      if (!br_s && rgb_s != 12'h000) n_rgb++;
      if (int'(hc_s) > max_h) max_h = int'(hc_s);
      if (int'(vc_s) > max_v) max_v = int'(vc_s);
      if (fs_s) begin
        n_fs++;
        if (exp_q.size() > 0) chk("small.frame_period", c - last_fs, int'(exp_q.pop_front()));
        else chk("small.frame_extra", 1, 0);
        last_fs = c;
      end
    end
    chk("small.fs_count", n_fs, 2);
    chk("small.exp_q_left", exp_q.size(), 0);
    chk("small.hs_high_clks", n_hs, 24);
    chk("small.vs_low_clks", n_vs, 16);
    chk("small.bright_clks", n_br, 24);
    chk("small.pix_tick_clks", n_pt, 96);
    chk("small.line_starts", n_ls, 12);
    chk("small.rgb_in_blank", n_rgb, 0);
    chk("small.max_h", max_h, 7);
    chk("small.max_v", max_v, 5);

    repeat (10) @(negedge clk);
    cmp_vec("small_pre_rst", 0, mk(0, 2, 1, 0, 1, 1, 0, 0, 1, 0, 12'h000), snap_s());
    #1 rst_s_n = 1'b0;
    #1 cmp_vec("small_async_rst", 0, mk(0, 7, 5, 0, 1, 0, 0, 0, 0, 1, 12'h000), snap_s());
    repeat (2) @(negedge clk);
    rst_s_n = 1'b1;
    @(negedge clk);
    cmp_vec("small_restart", 0, mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 12'h000), snap_s());

    // Default instance: table through the first line, one-line scan, mid-frame reset.
    rst_n = 1'b1;
    for (int i = 0; i < big_tab.size(); i++) begin
      repeat (big_tab[i].adv) @(negedge clk);
      cmp_vec("big", i, big_tab[i], snap_b());
    end

    cyc = 0; n_hs = 0; n_vs = 0; n_br = 0; n_pt = 0; n_rgb = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!hs) n_hs++;
      if (!vs) n_vs++;
      if (br) n_br++;
      if (pt) n_pt++;
      if (!br && rgb != 12'h000) n_rgb++;
    end while (!ls && cyc < 4000);
    chk("big.line_period", cyc, 3200);
    chk("big.hs_low_clks", n_hs, 384);
    chk("big.vs_low_clks", n_vs, 0);
    chk("big.bright_clks", n_br, 2560);
    chk("big.pix_ticks", n_pt, 800);
    chk("big.rgb_in_blank", n_rgb, 0);

    repeat (1200) @(negedge clk);
    cmp_vec("big_pre_rst", 0, mk(0, 300, 2, 1, 1, 1, 0, 0, 1, 1, 12'h0F0), snap_b());
    #1 rst_n = 1'b0;
    #1 cmp_vec("big_async_rst", 0, mk(0, 799, 524, 1, 1, 0, 0, 0, 0, 1, 12'h000), snap_b());
    repeat (3) @(negedge clk);
    cmp_vec("big_held_rst", 0, mk(0, 799, 524, 1, 1, 0, 0, 0, 0, 1, 12'h000), snap_b());
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    cmp_vec("big_rel3", 0, mk(0, 799, 524, 1, 1, 0, 0, 0, 0, 1, 12'h000), snap_b());
    @(negedge clk);
    cmp_vec("big_restart", 0, mk(0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 12'hFFF), snap_b());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
